// File: rtl/ahb_slave_mem_if.sv
// AHB slave-side signal bundle for ahb_slave_mem. The master drives the
// address, control and write data; the slave returns ready, response and read data.
interface ahb_slave_mem_if;
    logic        Hselx;
    logic [31:0] Haddr;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [2:0]  Hburst;
    logic [3:0]  Hprot;
    logic [1:0]  Htrans;
    logic        Hmastlock;
    logic        Hready;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic        Hresp;
    logic [31:0] Hrdata;

    modport master (
        output Hselx, Haddr, Hwrite, Hsize, Hburst, Hprot, Htrans, Hmastlock, Hready, Hwdata,
        input  Hreadyout, Hresp, Hrdata
    );

    modport slave (
        input  Hselx, Haddr, Hwrite, Hsize, Hburst, Hprot, Htrans, Hmastlock, Hready, Hwdata,
        output Hreadyout, Hresp, Hrdata
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB5 slave with word-addressed memory, byte-lane writes and a two-cycle ERROR.
// Wait-state insertion is built only when AHB_SLV_WAIT_EN is defined.
module ahb_slave_mem #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic           Hclk,
    input  logic           Hreset,
    ahb_slave_mem_if.slave ahb
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int AW    = IDX_W + 2;
    localparam logic [32:0] BYTE_LIMIT = 33'(MEM_DEPTH * 4);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t           state_reg, state_next;
    logic [AW-1:0]    addr_reg;
    logic             write_reg;
    logic [1:0]       size_reg;

    logic [31:0]      mem [MEM_DEPTH];
    logic [31:0]      mem_q_reg;
    logic [3:0]       fwd_be_reg;
    logic [31:0]      fwd_data_reg;

    logic             accept;
    logic             can_accept;
    logic             take;
    logic             align_ok;
    logic             req_err;
    logic             wr_commit;
    logic             rd_load;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [3:0]       be;
    logic [31:0]      rd_merged;
    logic             readyout_c;
    logic             resp_c;
    logic [31:0]      rdata_c;

    logic             unused_bits;
    assign unused_bits = ^{ahb.Hburst, ahb.Hprot, ahb.Hmastlock, ahb.Htrans[0]};

`ifdef AHB_SLV_WAIT_EN
    localparam bit         USE_WAIT  = (WAIT_STATES != 0);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
    logic [3:0] wait_cnt_reg, wait_cnt_next;
`else
    localparam bit USE_WAIT = 1'b0;
`endif

    // Address-phase decode and legality check
    assign accept     = ahb.Hselx && ahb.Hready && ahb.Htrans[1];
    assign can_accept = (state_reg == ST_IDLE) || (state_reg == ST_DATA) || (state_reg == ST_ERR2);
    assign take       = can_accept && accept;

    always_comb begin
        align_ok = 1'b0;
        case (ahb.Hsize)
            3'd0:    align_ok = 1'b1;
            3'd1:    align_ok = !ahb.Haddr[0];
            3'd2:    align_ok = (ahb.Haddr[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

    assign req_err = ({1'b0, ahb.Haddr} >= BYTE_LIMIT) || !align_ok;

    // State register
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept) begin
                    if (req_err) begin
                        state_next = ST_ERR1;
                    end else begin
                        state_next = USE_WAIT ? ST_WAIT : ST_DATA;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
`ifdef AHB_SLV_WAIT_EN
            ST_WAIT: begin
                if (wait_cnt_reg <= 4'd1) begin
                    state_next = ST_DATA;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs; an asserted reset forces the idle response in the same cycle
    always_comb begin
        readyout_c = 1'b1;
        resp_c     = 1'b0;
        rdata_c    = '0;
        if (!Hreset) begin
            case (state_reg)
                ST_WAIT: readyout_c = 1'b0;
                ST_ERR1: begin
                    readyout_c = 1'b0;
                    resp_c     = 1'b1;
                end
                ST_ERR2: resp_c = 1'b1;
                ST_DATA: if (!write_reg) rdata_c = rd_merged;
                default: ;
            endcase
        end
    end

    assign ahb.Hreadyout = readyout_c;
    assign ahb.Hresp     = resp_c;
    assign ahb.Hrdata    = rdata_c;

`ifdef AHB_SLV_WAIT_EN
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (take && !req_err) begin
            wait_cnt_next = WAIT_LOAD;
        end else if (state_reg == ST_WAIT) begin
            wait_cnt_next = wait_cnt_reg - 4'd1;
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            wait_cnt_reg <= 4'd0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`endif

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            addr_reg  <= '0;
            write_reg <= 1'b0;
            size_reg  <= 2'd0;
        end else if (take) begin
            addr_reg  <= ahb.Haddr[AW-1:0];
            write_reg <= ahb.Hwrite;
            size_reg  <= ahb.Hsize[1:0];
        end
    end

    assign wr_idx    = addr_reg[AW-1:2];
    assign rd_idx    = ahb.Haddr[AW-1:2];
    assign wr_commit = !Hreset && (state_reg == ST_DATA) && write_reg;
    assign rd_load   = !Hreset && take && !req_err && !ahb.Hwrite;

    // Little-endian lane enables and read-data merge with a same-edge write
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign be[gi] = (size_reg == 2'd2)
                     || ((size_reg == 2'd1) && (addr_reg[1] == LANE[1]))
                     || ((size_reg == 2'd0) && (addr_reg[1:0] == LANE));
        assign rd_merged[gi*8 +: 8] = fwd_be_reg[gi] ? fwd_data_reg[gi*8 +: 8]
                                                     : mem_q_reg[gi*8 +: 8];
    end

    // Memory array: byte-enabled write, registered read captured at read acceptance
    always_ff @(posedge Hclk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_commit && be[b]) begin
                mem[wr_idx][b*8 +: 8] <= ahb.Hwdata[b*8 +: 8];
            end
        end
        if (rd_load) begin
            mem_q_reg <= mem[rd_idx];
        end
    end

    // A read accepted on the edge where a write to the same word commits sees the new bytes
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            fwd_be_reg   <= '0;
            fwd_data_reg <= '0;
        end else if (rd_load) begin
            fwd_be_reg   <= (wr_commit && (wr_idx == rd_idx)) ? be : 4'b0000;
            fwd_data_reg <= ahb.Hwdata;
        end
    end
endmodule
